// File: rtl/mux_registrado.sv
// Registered N-way word selector with a one-cycle valid/error strobe and a
// scan mode that walks the inputs in order using an internal wrapping counter.
module mux_registrado #(
   parameter int LARGURA      = 32,
   parameter int NUM_ENTRADAS = 11,
   parameter int SEL_LARGURA  = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_ENTRADAS*LARGURA-1:0] entradas,
   input  logic [SEL_LARGURA-1:0]          controle,
   input  logic                            carrega,
   input  logic                            modo,
   input  logic                            zera_contador,
   output logic [LARGURA-1:0]              saida,
   output logic                            valida,
   output logic                            erro,
   output logic [SEL_LARGURA-1:0]          indice
);

   // One extra bit so NUM_ENTRADAS == 2**SEL_LARGURA is still representable.
   localparam logic [SEL_LARGURA:0]   N_EXT  = (SEL_LARGURA+1)'(NUM_ENTRADAS);
   localparam logic [SEL_LARGURA-1:0] ULTIMO = SEL_LARGURA'(NUM_ENTRADAS - 1);

   logic [SEL_LARGURA-1:0] contador;
   logic [SEL_LARGURA-1:0] sel_scan;
   logic [SEL_LARGURA-1:0] sel;
   logic                   em_faixa;
   logic [LARGURA-1:0]     palavra;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      sel_scan = zera_contador ? '0 : contador;
      sel      = modo ? sel_scan : controle;
      em_faixa = modo | ({1'b0, controle} < N_EXT);
      palavra  = '0;
      // Explicit compare per input keeps an out-of-range select at zero, never X.
      for (int k = 0; k < NUM_ENTRADAS; k++) begin
         if (sel == SEL_LARGURA'(k)) begin
            palavra = entradas[k*LARGURA +: LARGURA];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         saida    <= '0;
         valida   <= 1'b0;
         erro     <= 1'b0;
         indice   <= '0;
         contador <= '0;
      end else begin
         valida <= 1'b0;
         erro   <= 1'b0;
         if (carrega && em_faixa) begin
            saida  <= palavra;
            indice <= sel;
            valida <= 1'b1;
         end else if (carrega) begin
            erro <= 1'b1;
         end

         if (carrega && modo) begin
            contador <= (sel_scan == ULTIMO) ? '0 : sel_scan + 1'b1;
         end else if (zera_contador) begin
            contador <= '0;
         end
      end
   end

endmodule
